puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Controller that drives the 8-bit, 8-response arbiter PUF array.
- On a host start command it walks an LFSR-generated challenge sequence. For each challenge it sequences a settle phase and an evaluate phase on the PUF enable, repeats the evaluation NVOTE times, and majority-votes each response bit.
- Each stabilised challenge/response pair is presented on a valid/ready stream toward the host or key-generation logic.

Parameters:
- SETUP_CYC, 2, cycles challenge is held stable with puf_en low before each evaluation (>=1)
- EVAL_CYC, 4, cycles puf_en is held high per evaluation (>=1)
- NVOTE, 5, evaluations per challenge for majority vote (odd, 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command; accepted only in IDLE
- seed  in  8  first challenge; 8'h00 is replaced by 8'h01
- num_ch  in  8  number of challenges; 0 means 256
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last pair is accepted
- puf_en  out  1  enable to the PUF array
- puf_challenge  out  8  challenge to the PUF array (registered)
- puf_response  in  8  response from the PUF array
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready
- out_challenge  out  8  challenge of the presented pair
- out_response  out  8  majority-voted response

Behaviour:
- Reset (async assert, sync-release assumed upstream): FSM=IDLE; all outputs 0; vote counters 0; rep and challenge counters 0.
- States: IDLE, SETUP, EVAL, OUT. All outputs are registered.

State transitions:
- IDLE: start=1 at edge k -> latch puf_challenge=(seed==0?1:seed), remaining=num_ch (0 -> 256), clear counters -> SETUP. start in any other state is ignored.
- SETUP: puf_en=0 for SETUP_CYC cycles -> EVAL.
- EVAL: puf_en=1 for EVAL_CYC cycles. On the edge ending the final EVAL cycle:
  - sample puf_response and increment vote_cnt[i] for each bit i that is set;
  - if rep<NVOTE-1, then rep++ -> SETUP;
  - otherwise -> OUT with out_response[i]=(vote_cnt_final[i] > NVOTE/2), where the final count includes this sample, and out_challenge=puf_challenge.
- OUT: out_valid=1, puf_en=0. out_valid, out_challenge and out_response are held stable until the handshake.
  - On out_valid&&out_ready: out_valid=0, clear votes and rep.
  - If remaining==1: -> IDLE with done=1 for one cycle.
  - Otherwise: remaining--, puf_challenge=lfsr_next(puf_challenge) -> SETUP.

Timing and arithmetic:
- Latency: first out_valid rises after edge k+NVOTE*(SETUP_CYC+EVAL_CYC). With out_ready tied high, throughput is one pair per NVOTE*(SETUP_CYC+EVAL_CYC)+1 cycles.
- LFSR (x^8+x^6+x^5+x^4+1, Fibonacci): next={c[6:0], c[7]^c[5]^c[4]^c[3]}. The LFSR never reaches 0 from a nonzero seed.
- puf_challenge changes only on the OUT->SETUP or IDLE->SETUP transition, never while puf_en=1.
- Vote counters are 4 bits per response bit and cannot overflow because NVOTE<=15.

Boundary conditions:
- Back-pressure of any length in OUT is legal; no sampling occurs during it.
- num_ch=1: exactly one pair, then done.
- rst_n low mid-sequence: immediate return to IDLE, puf_en=0, out_valid=0, and no done pulse.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, SETUP, EVAL, OUT);
  - LFSR tap constant 8'hB8 and a function lfsr8_next;
  - widths CH_W=8, RESP_W=8.
- One natural sub-module: puf_majority_vote. It holds the per-bit vote counters, with inputs clear, sample_en, resp[7:0] and output majority[7:0]. The FSM and counters stay in the top-level sequencer.

Test Plan:
- Defaults, ideal PUF model returning ~challenge, out_ready=1; start with seed=8'h01, num_ch=3 -> pairs (01,FE), (02,FD), (04,FB); first out_valid exactly 30 cycles after start edge; done pulses once; busy low after.
- seed=8'h00, num_ch=1 -> single pair with challenge 8'h01; done one cycle after the handshake.
- Noisy model: bit0 is 1 on 3 of 5 evaluations and bit1 is 1 on 2 of 5 -> out_response[0]=1, out_response[1]=0.
- Hold out_ready=0 for 50 cycles in OUT -> out_valid, out_challenge and out_response stable; puf_en=0; no extra samples taken; release -> the sequence continues normally.
- Assert rst_n low during EVAL of the 2nd challenge -> puf_en, out_valid, busy and done all 0 immediately. Restart with seed=8'h10 -> first challenge is 8'h10.
- num_ch=0 with seed 8'h01 -> 256 pairs; the challenge sequence follows the LFSR with no 8'h00 and 255-period wrap (pair 256 challenge = 8'h01).

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF challenge sequencer.
package puf_pkg;

  localparam int CH_W   = 8;
  localparam int RESP_W = 8;

  // Taps of x^8+x^6+x^5+x^4+1 as a mask over challenge bits 7,5,4,3.
  localparam logic [CH_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EVAL  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic logic [CH_W-1:0] lfsr8_next(input logic [CH_W-1:0] c);
    return {c[CH_W-2:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_majority_vote.sv
// Per-bit vote counters; majority includes the sample being taken this cycle.
module puf_majority_vote
  import puf_pkg::*;
#(
  parameter int NVOTE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] majority
);

  logic [3:0] cnt_q [RESP_W];
  logic [3:0] cnt_d [RESP_W];
  logic [4:0] tally;

  always_comb begin
    tally    = 5'd0;
    majority = '0;
    for (int i = 0; i < RESP_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = 4'd0;
      end else if (sample_en && resp[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
      tally       = {1'b0, cnt_q[i]} + {4'd0, sample_en & resp[i]};
      majority[i] = (tally > 5'(NVOTE / 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks an LFSR challenge sequence, evaluates each challenge NVOTE times on the
// PUF and streams majority-voted pairs. Output stream: a pair transfers on a
// rising edge where out_valid && out_ready; out_valid and its data hold until then.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int EVAL_CYC  = 4,
  parameter int NVOTE     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   seed,
  input  logic [7:0]        num_ch,
  output logic              busy,
  output logic              done,
  output logic              puf_en,
  output logic [CH_W-1:0]   puf_challenge,
  input  logic [RESP_W-1:0] puf_response,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_challenge,
  output logic [RESP_W-1:0] out_response,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [3:0]        rep_q, rep_d;
  logic [8:0]        remain_q, remain_d;
  logic [CH_W-1:0]   chal_q, chal_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [RESP_W-1:0] out_resp_q, out_resp_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              puf_en_q, puf_en_d, out_valid_q, out_valid_d;
  logic              sample_en, vote_clear, handshake;
  logic [RESP_W-1:0] majority;

  assign sample_en  = (state_q == ST_EVAL) && (cyc_q == 8'(EVAL_CYC - 1));
  assign handshake  = (state_q == ST_OUT) && out_ready;
  assign vote_clear = handshake || ((state_q == ST_IDLE) && start);

  puf_majority_vote #(.NVOTE(NVOTE)) u_vote (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (vote_clear),
    .sample_en (sample_en),
    .resp      (puf_response),
    .majority  (majority)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    rep_d      = rep_q;
    remain_d   = remain_q;
    chal_d     = chal_q;
    out_ch_d   = out_ch_q;
    out_resp_d = out_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          chal_d   = (seed == '0) ? CH_W'(1) : seed;
          remain_d = (num_ch == 8'd0) ? 9'd256 : {1'b0, num_ch};
          cyc_d    = 8'd0;
          rep_d    = 4'd0;
        end
      end
      ST_SETUP: begin
        if (cyc_q == 8'(SETUP_CYC - 1)) begin
          cyc_d   = 8'd0;
          state_d = ST_EVAL;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_EVAL: begin
        if (sample_en) begin
          cyc_d = 8'd0;
          if (rep_q < 4'(NVOTE - 1)) begin
            rep_d   = rep_q + 4'd1;
            state_d = ST_SETUP;
          end else begin
            state_d    = ST_OUT;
            out_ch_d   = chal_q;
            out_resp_d = majority;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          rep_d = 4'd0;
          if (remain_q == 9'd1) begin
            state_d = ST_IDLE;
          end else begin
            remain_d = remain_q - 9'd1;
            chal_d   = lfsr8_next(chal_q);
            state_d  = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    puf_en_d    = (state_d == ST_EVAL);
    out_valid_d = (state_d == ST_OUT);
    done_d      = handshake && (remain_q == 9'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 8'd0;
      rep_q       <= 4'd0;
      remain_q    <= 9'd0;
      chal_q      <= '0;
      out_ch_q    <= '0;
      out_resp_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      puf_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      rep_q       <= rep_d;
      remain_q    <= remain_d;
      chal_q      <= chal_d;
      out_ch_q    <= out_ch_d;
      out_resp_q  <= out_resp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      puf_en_q    <= puf_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign puf_en        = puf_en_q;
  assign puf_challenge = chal_q;
  assign out_valid     = out_valid_q;
  assign out_challenge = out_ch_q;
  assign out_response  = out_resp_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: table of runs against a vote/LFSR model,
// plus directed reset-mid-sequence and restart checks.
module tb_puf_challenge_sequencer;

  localparam int SETUP_CYC = 2;
  localparam int EVAL_CYC  = 4;
  localparam int NVOTE     = 5;
  localparam int PAIR_CYC  = NVOTE * (SETUP_CYC + EVAL_CYC);
  localparam int NMAX      = 256 * NVOTE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] num_ch = 8'h00;
  logic       busy, done, puf_en, out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] puf_challenge, puf_response, out_challenge, out_response;
  logic [1:0] dbg_state;

  puf_challenge_sequencer #(
    .SETUP_CYC(SETUP_CYC), .EVAL_CYC(EVAL_CYC), .NVOTE(NVOTE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_ch(num_ch),
    .busy(busy), .done(done), .puf_en(puf_en), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .out_valid(out_valid), .out_ready(out_ready),
    .out_challenge(out_challenge), .out_response(out_response), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // PUF model: ideal response ~challenge, xor a per-evaluation noise word.
  logic [7:0] noise [NMAX];
  int         eval_idx = 0;
  int         eval_base = 0;
  logic       prev_en = 1'b0;
  logic [7:0] noise_sel;

  always @* begin
    noise_sel = 8'h00;
    if ((eval_idx - eval_base) >= 0 && (eval_idx - eval_base) < NMAX)
      noise_sel = noise[eval_idx - eval_base];
  end
  assign puf_response = ~puf_challenge ^ noise_sel;

  always @(negedge clk) begin
    if (prev_en && !puf_en) eval_idx <= eval_idx + 1;
    prev_en <= puf_en;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  got_ch [256];
  logic [7:0]  got_resp [256];
  int          n_got;

  typedef struct {
    logic [7:0] seed;
    logic [7:0] num;
    int         noise_mode;
    int         ready_mode;
    logic [7:0] exp_first;
  } vec_t;
  vec_t tab[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [7:0] ref_lfsr(input logic [7:0] c);
    logic fb;
    fb = c[7] ^ c[5] ^ c[4] ^ c[3];
    return {c[6:0], fb};
  endfunction

  function automatic logic [7:0] ref_vote(input logic [7:0] ch, input int first_eval);
    logic [7:0] r, res;
    int cnt;
    res = 8'h00;
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int e = 0; e < NVOTE; e++) begin
        r = ~ch ^ noise[first_eval + e];
        cnt += int'(r[b]);
      end
      res[b] = (cnt > NVOTE / 2);
    end
    return res;
  endfunction

  function automatic vec_t mk(input logic [7:0] s, input logic [7:0] n, input int nm, input int rm);
    vec_t v;
    v.seed = s; v.num = n; v.noise_mode = nm; v.ready_mode = rm;
    v.exp_first = (s == 8'h00) ? 8'h01 : s;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n, cyc, iter, hs_iter, done_cnt, stall, budget;
    logic finished, last_v, last_hs, last_en;
    logic [15:0] last_pair, e;
    logic [7:0] ch, last_pc;
    n = (v.num == 8'h00) ? 256 : int'(v.num);
    for (int k = 0; k < n * NVOTE; k++) begin
      case (v.noise_mode)
        1: noise[k] = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        2: noise[k] = {6'd0, (k >= 2), (k < 3)};
        default: noise[k] = 8'h00;
      endcase
    end
    eval_base = eval_idx;
    exp_q.delete();
    ch = (v.seed == 8'h00) ? 8'h01 : v.seed;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({ch, ref_vote(ch, j * NVOTE)});
      ch = ref_lfsr(ch);
    end
    n_got = 0;
    out_ready = (v.ready_mode == 0);
    seed = v.seed; num_ch = v.num; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < PAIR_CYC + 20 && !out_valid) begin
      @(posedge clk); cyc++; #1;
    end
    chk("first_valid_latency", cyc, PAIR_CYC);
    chk("busy_running", busy, 1'b1);
    iter = 0; hs_iter = -100; done_cnt = 0; stall = 0; finished = 1'b0;
    last_v = 1'b0; last_hs = 1'b0; last_en = 1'b0; last_pair = 16'h0; last_pc = 8'h0;
    budget = n * (PAIR_CYC + 1) * 3 + 200;
    while (!finished && iter < budget) begin
      case (v.ready_mode)
        1: begin
          out_ready = ($urandom_range(0, 3) != 0);
          start = busy && ($urandom_range(0, 7) == 0);
          seed = 8'($urandom_range(0, 255)); num_ch = 8'($urandom_range(0, 255));
        end
        2: begin
          if (out_valid && stall < 50) begin out_ready = 1'b0; stall++; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (out_valid) begin
        chk("puf_en_low_in_out", puf_en, 1'b0);
        if (last_v && !last_hs) chk("out_hold_stable", {out_challenge, out_response}, last_pair);
      end
      if (puf_en && last_en) chk("challenge_stable_eval", puf_challenge, last_pc);
      if (done) begin
        done_cnt++;
        chk("done_after_last_hs", iter - hs_iter, 1);
        chk("queue_drained_at_done", exp_q.size(), 0);
        finished = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pair", n_got, n - 1);
        end else begin
          e = exp_q.pop_front();
          chk("pair", {out_challenge, out_response}, e);
        end
        if (n_got < 256) begin got_ch[n_got] = out_challenge; got_resp[n_got] = out_response; end
        if (v.ready_mode == 0 && n_got > 0) chk("throughput", iter - hs_iter, PAIR_CYC + 1);
        hs_iter = iter;
        n_got++;
      end
      last_v = out_valid; last_hs = out_valid && out_ready;
      last_pair = {out_challenge, out_response};
      last_en = puf_en; last_pc = puf_challenge;
      @(posedge clk); #1;
      start = 1'b0;
      iter++;
    end
    chk("finished_in_budget", finished, 1'b1);
    chk("pairs_received", n_got, n);
    chk("done_pulses", done_cnt, 1);
    chk("eval_count", eval_idx - eval_base, n * NVOTE);
    if (n_got > 0) chk("first_challenge", got_ch[0], v.exp_first);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("state_idle_after", dbg_state, 2'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0]  = mk(8'h01, 8'd3, 0, 0);
    tab[1]  = mk(8'h00, 8'd1, 0, 0);
    tab[2]  = mk(8'h01, 8'd1, 2, 0);
    tab[3]  = mk(8'h5A, 8'd4, 0, 2);
    for (int i = 4; i < 10; i++)
      tab[i] = mk(8'($urandom_range(0, 255)), 8'($urandom_range(1, 6)), 1, 1);
    tab[10] = mk(8'h01, 8'd0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_puf_en", puf_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_challenge", puf_challenge, 8'h00);
    chk("rst_out_pair", {out_challenge, out_response}, 16'h0000);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_vec(tab[i]);
      if (i == 0) begin
        chk("seq_pair0", {got_ch[0], got_resp[0]}, 16'h01FE);
        chk("seq_pair1", {got_ch[1], got_resp[1]}, 16'h02FD);
        chk("seq_pair2", {got_ch[2], got_resp[2]}, 16'h04FB);
      end
      if (i == 2) chk("noisy_vote", got_resp[0], 8'hFD);
      if (i == 10) begin
        chk("wrap_pair256", got_ch[255], 8'h01);
        for (int j = 0; j < 256; j++) chk("no_zero_challenge", (got_ch[j] == 8'h00), 1'b0);
      end
    end

    // Reset asserted during the second challenge's evaluation.
    for (int k = 0; k < 3 * NVOTE; k++) noise[k] = 8'h00;
    eval_base = eval_idx;
    out_ready = 1'b1; seed = 8'h01; num_ch = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PAIR_CYC + 1 + SETUP_CYC) @(posedge clk);
    #2;
    chk("in_eval_2nd", {dbg_state, puf_en, puf_challenge}, {2'd2, 1'b1, 8'h02});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_puf_en", puf_en, 1'b0);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", {done, busy}, 2'b00);
    end
    @(posedge clk); #1;
    run_vec(mk(8'h10, 8'd2, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
